// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier
// Multi-cycle radix-2 Booth multiplier with valid/ready handshakes on the
// operand side (src_*) and the product side (dest_*). One WIDTH+1 bit
// adder/subtractor is reused for WIDTH+1 steps per transaction.
//
// Optional build macro: MULT_UNSIGNED_EN
//   defined   -> is_signed port present; is_signed=0 zero-extends a and b
//   undefined -> no is_signed port; operands are always sign-extended
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, src_ready=1
// CALC  | one Booth step (add/sub + arithmetic shift) per cycle
// DONE  | product held with dest_valid=1 until dest_ready
module seq_signed_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULT_UNSIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 dest_valid,
  input  logic                 dest_ready,
  output logic [2*WIDTH-1:0]   product
);

  // Extended operand width and accumulator layout:
  // acc = {upper (EW bits), extended multiplier (EW bits), q-1 (1 bit)}
  localparam int EW = WIDTH + 1;
  localparam int AW = 2 * WIDTH + 3;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            last_step;
  logic            ext_en;
  logic [EW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;
  logic [EW-1:0]   mcand;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   acc_shift;
  logic [EW-1:0]   upper_sum;
  logic [CW-1:0]   step;

`ifdef MULT_UNSIGNED_EN
  assign ext_en = is_signed;
`else
  assign ext_en = 1'b1;
`endif

  // Extension to WIDTH+1 bits means the add/subtract can never overflow.
  assign a_ext = {ext_en & a[WIDTH-1], a};
  assign b_ext = {ext_en & b[WIDTH-1], b};

  // Outputs decode from registered state only, so no input reaches an output.
  assign src_ready  = (state == IDLE);
  assign dest_valid = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake/step qualifiers
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (src_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (step == LAST_STEP) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (dest_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One Booth step: examine {q0, q-1}, add/sub into the upper half, then
  // shift the whole accumulator right arithmetically by one.
  always_comb begin
    upper_sum = acc[AW-1 -: EW];
    case (acc[1:0])
      2'b01:   upper_sum = acc[AW-1 -: EW] + mcand;
      2'b10:   upper_sum = acc[AW-1 -: EW] - mcand;
      default: upper_sum = acc[AW-1 -: EW];
    endcase
    acc_shift = {upper_sum[EW-1], upper_sum, acc[EW:1]};
  end

  // Datapath registers: operand capture, step iteration, product load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      step    <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a_ext;
      acc   <= {{EW{1'b0}}, b_ext, 1'b0};
      step  <= '0;
    end else if (state == CALC) begin
      acc  <= acc_shift;
      step <= step + CW'(1);
      if (last_step) begin
        product <= acc_shift[2*WIDTH:1];
      end
    end
  end

endmodule
